ctrl_unit: RTL and testbench
============================

# ctrl_unit

Hardwired, multi-cycle control unit that sequences the `ALU_System` datapath. It fetches a 16-bit instruction, low byte then high byte, from memory into the IR. It then decodes `IR_Out` and drives every mux select, register-file, address-register-file, IR and memory control for one to two execute cycles before the next fetch. `ctrl_unit` and `ALU_System` are instantiated side by side in a CPU top level; `ctrl_unit` consumes only `IR_Out` and the ALU flags.

## Interface
- No parameters. All encodings are fixed constants (see Structure).
- `Clock` in 1: single system clock, rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `IR_Out` in 16: current instruction. `[15:12]` opcode, `[11:10]` Rx, `[9:8]` Ry, `[7:0]` address/immediate.
- `ZCNO` in 4: registered ALU flags; Z is `ZCNO[3]`.
- `MuxASel`, `MuxBSel` out 2; `MuxCSel` out 1: datapath mux selects.
- `RF_OutASel`, `RF_OutBSel` out 3; `RF_FunSel` out 2; `RF_RSel`, `RF_TSel` out 4: RF control.
- `ALU_FunSel` out 4: ALU operation.
- `ARF_OutASel`, `ARF_OutBSel`, `ARF_FunSel` out 2; `ARF_RSel` out 4: ARF control.
- `IR_Funsel` out 2; `IR_Enable`, `IR_LH` out 1: IR control.
- `Mem_WR`, `Mem_CS` out 1: memory control. Write is 1; chip select is active-low.
- `Halted` out 1: high while in `S_HALT`.

## Operation
- Fixed encodings:
  - FunSel for RF, ARF and IR: 00 dec, 01 inc, 10 load, 11 clear.
  - RF O-sel: 0xx selects T1..T4; 1xx selects R1..R4, so Rx maps to sel `{1'b1, Rx}`.
  - RF RSel is one-hot, with R1 = 4'b1000 and Rx=00 → R1.
  - ARF regs are 00 PC, 01 AR, 10 SP. ARF RSel is one-hot, PC = 4'b1000, AR = 4'b0100, SP = 4'b0010.
  - ALU FunSel: 0001 pass B, 0100 A+B, 0101 A−B.
- Idle (default) outputs: all RSel/TSel 0000, `IR_Enable` 0, `Mem_CS` 1, `Mem_WR` 0, all other selects 0. Every state not listed below drives these defaults.
- Outputs are a Moore/Mealy decode of the registered state plus `IR_Out`/`ZCNO`. There are no registered outputs.
- **S_INIT:** clear PC, AR and SP (ARF FunSel 11, RSel 1110); clear R1–R4 (RF FunSel 11, RSel 1111). Next state S_FETCH_L.
- **S_FETCH_L:** ARF_OutBSel=PC, Mem_CS=0, Mem_WR=0, IR_Enable=1, IR_Funsel=10, IR_LH=0, PC inc. Next state S_FETCH_H.
- **S_FETCH_H:** same as S_FETCH_L but IR_LH=1. Next state S_EX0.
- **S_EX0**, by opcode:
  - 0x0 LD / 0x1 ST: AR ← IR[7:0] (MuxBSel=10, ARF load AR). Next state S_EX1.
  - 0x2 MOVI: Rx ← IR[7:0] (MuxASel=10, RF load Rx).
  - 0x3 ADD / 0x4 SUB: Rx ← Rx ± Ry. RF_OutASel=Rx, MuxCSel=0, RF_OutBSel=Ry, ALU 0100/0101, MuxASel=00, RF load Rx.
  - 0x5 BRA: PC ← IR[7:0] (MuxBSel=10, ARF load PC).
  - 0x6 BEQ: as BRA only if ZCNO[3]=1; otherwise defaults.
  - 0xF HALT: next state S_HALT.
  - Any other opcode is a NOP.
  - Next state is S_FETCH_L unless stated otherwise.
- **S_EX1:**
  - LD: ARF_OutBSel=AR, Mem_CS=0, MuxASel=01, RF load Rx.
  - ST: RF_OutBSel=Rx, ALU 0001, ARF_OutBSel=AR, Mem_CS=0, Mem_WR=1.
  - Next state S_FETCH_L.
- **S_HALT:** defaults, `Halted`=1. Held until `Reset`.

## Timing
- While `Reset`=0: state is S_INIT, asynchronously. Outputs during reset equal the S_INIT decode, and `Halted`=0.
  - The first S_INIT clearing edge is the first rising `Clock` after `Reset` deasserts.
  - Reset mid-instruction aborts immediately. `Mem_CS` returns to 1 combinationally, so no partial store occurs.
- Cycles per instruction, including 2 fetch cycles:
  - MOVI/ADD/SUB/BRA/BEQ/NOP: 3.
  - LD/ST: 4.
- Memory read is combinational on address and captured at the edge ending the state.
- The BEQ decision uses ZCNO as it stands during S_EX0, i.e. the flags from the last ALU-flag update.
- PC is 8-bit and wraps 0xFF→0x00 on increment; there is no special handling.

## Structure
- Package `ctrl_pkg`:
  - state enum (S_INIT, S_FETCH_L, S_FETCH_H, S_EX0, S_EX1, S_HALT);
  - opcode constants;
  - FunSel/ALU codes;
  - RF/ARF select and one-hot RSel constants.
- Single module with a state register plus a combinational decode block. No sub-module is needed.

## Test plan
- **Reset/init:** Reset low mid-S_EX1 of ST → `Mem_CS`=1 at once. After release, S_INIT clears PC=0 and R1..R4=0, then fetch from address 0x00.
- **Immediate and ALU:** MOVI R1,0x05; MOVI R2,0x03; SUB R1,R2 → R1=0x02 after 9 cycles, and `Mem_WR` is never 1.
- **Load/store:** M[0x40]=0xA5; LD R3,0x40; ST R3,0x41 → M[0x41]=0xA5. Each instruction takes 4 cycles, and Mem_WR=1 is asserted for exactly 1 cycle.
- **Branches:** after SUB yielding 0 (Z=1), BEQ 0x20 → next fetch address 0x20. With Z=0, the next fetch is PC+2.
- **Halt:** HALT → `Halted`=1, outputs idle and PC frozen for ≥10 cycles. Reset recovers.
- **Undefined opcode and wrap:** opcode 0x9 → NOP (3 cycles). An instruction at 0xFE..0xFF is followed by a fetch from 0x00.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired ALU_System control unit: states, opcodes,
// function-select codes, register selects and the decoded control word.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_INIT, S_FETCH_L, S_FETCH_H, S_EX0, S_EX1, S_HALT
  } state_t;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_MOVI = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_BRA  = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  // FunSel shared by RF, ARF and IR
  localparam logic [1:0] FS_DEC  = 2'b00;
  localparam logic [1:0] FS_INC  = 2'b01;
  localparam logic [1:0] FS_LOAD = 2'b10;
  localparam logic [1:0] FS_CLR  = 2'b11;

  localparam logic [3:0] ALU_PASSB = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;

  localparam logic [1:0] ARF_PC = 2'b00;
  localparam logic [1:0] ARF_AR = 2'b01;
  localparam logic [1:0] ARF_SP = 2'b10;

  localparam logic [3:0] RSEL_PC  = 4'b1000;
  localparam logic [3:0] RSEL_AR  = 4'b0100;
  localparam logic [3:0] RSEL_SP  = 4'b0010;
  localparam logic [3:0] RSEL_ALL = 4'b1111;

  localparam logic [1:0] MUXA_ALU = 2'b00;
  localparam logic [1:0] MUXA_MEM = 2'b01;
  localparam logic [1:0] MUXA_IMM = 2'b10;
  localparam logic [1:0] MUXB_IMM = 2'b10;

  typedef struct packed {
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic [2:0] rf_oa;
    logic [2:0] rf_ob;
    logic [1:0] rf_fun;
    logic [3:0] rf_rsel;
    logic [3:0] rf_tsel;
    logic [3:0] alu_fun;
    logic [1:0] arf_oa;
    logic [1:0] arf_ob;
    logic [1:0] arf_fun;
    logic [3:0] arf_rsel;
    logic [1:0] ir_fun;
    logic       ir_en;
    logic       ir_lh;
    logic       mem_wr;
    logic       mem_cs;
    logic       halted;
  } ctrl_t;

  // Rx/Ry field to RF output select: upper half of the select space is R1..R4
  function automatic logic [2:0] rf_osel(input logic [1:0] r);
    return {1'b1, r};
  endfunction

  // Rx field to one-hot RF RSel, R1 in the MSB
  function automatic logic [3:0] rf_onehot(input logic [1:0] r);
    return 4'b1000 >> r;
  endfunction

endpackage

// File: rtl/ctrl_unit.sv
// Multi-cycle hardwired controller: two-byte fetch into IR, then one or two
// execute cycles decoded from the registered state, IR_Out and the Z flag.
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Out,
  input  logic [3:0]  ZCNO,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [1:0]  RF_FunSel,
  output logic [3:0]  RF_RSel,
  output logic [3:0]  RF_TSel,
  output logic [3:0]  ALU_FunSel,
  output logic [1:0]  ARF_OutASel,
  output logic [1:0]  ARF_OutBSel,
  output logic [1:0]  ARF_FunSel,
  output logic [3:0]  ARF_RSel,
  output logic [1:0]  IR_Funsel,
  output logic        IR_Enable,
  output logic        IR_LH,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic        Halted
);

  state_t     state, state_nxt;
  ctrl_t      c;
  logic [3:0] op;
  logic [1:0] rx, ry;
  logic       unused_ok;

  assign op = IR_Out[15:12];
  assign rx = IR_Out[11:10];
  assign ry = IR_Out[9:8];
  // Immediate and C/N/O flags only matter to the datapath
  assign unused_ok = ^{IR_Out[7:0], ZCNO[2:0]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:    state_nxt = S_FETCH_L;
      S_FETCH_L: state_nxt = S_FETCH_H;
      S_FETCH_H: state_nxt = S_EX0;
      S_EX0: begin
        case (op)
          OP_LD, OP_ST: state_nxt = S_EX1;
          OP_HALT:      state_nxt = S_HALT;
          default:      state_nxt = S_FETCH_L;
        endcase
      end
      S_EX1:     state_nxt = S_FETCH_L;
      S_HALT:    state_nxt = S_HALT;
      default:   state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    c        = '0;
    c.mem_cs = 1'b1;
    case (state)
      S_INIT: begin
        c.arf_fun  = FS_CLR;
        c.arf_rsel = RSEL_PC | RSEL_AR | RSEL_SP;
        c.rf_fun   = FS_CLR;
        c.rf_rsel  = RSEL_ALL;
      end
      S_FETCH_L, S_FETCH_H: begin
        c.arf_ob   = ARF_PC;
        c.mem_cs   = 1'b0;
        c.ir_en    = 1'b1;
        c.ir_fun   = FS_LOAD;
        c.ir_lh    = (state == S_FETCH_H);
        c.arf_fun  = FS_INC;
        c.arf_rsel = RSEL_PC;
      end
      S_EX0: begin
        case (op)
          OP_LD, OP_ST: begin
            c.mux_b    = MUXB_IMM;
            c.arf_fun  = FS_LOAD;
            c.arf_rsel = RSEL_AR;
          end
          OP_MOVI: begin
            c.mux_a   = MUXA_IMM;
            c.rf_fun  = FS_LOAD;
            c.rf_rsel = rf_onehot(rx);
          end
          OP_ADD, OP_SUB: begin
            c.rf_oa   = rf_osel(rx);
            c.mux_c   = 1'b0;
            c.rf_ob   = rf_osel(ry);
            c.alu_fun = (op == OP_ADD) ? ALU_ADD : ALU_SUB;
            c.mux_a   = MUXA_ALU;
            c.rf_fun  = FS_LOAD;
            c.rf_rsel = rf_onehot(rx);
          end
          OP_BRA, OP_BEQ: begin
            // BEQ falls through to idle when Z is clear
            if (op == OP_BRA || ZCNO[3]) begin
              c.mux_b    = MUXB_IMM;
              c.arf_fun  = FS_LOAD;
              c.arf_rsel = RSEL_PC;
            end
          end
          default: ;
        endcase
      end
      S_EX1: begin
        if (op == OP_LD) begin
          c.arf_ob  = ARF_AR;
          c.mem_cs  = 1'b0;
          c.mux_a   = MUXA_MEM;
          c.rf_fun  = FS_LOAD;
          c.rf_rsel = rf_onehot(rx);
        end else if (op == OP_ST) begin
          c.rf_ob   = rf_osel(rx);
          c.alu_fun = ALU_PASSB;
          c.arf_ob  = ARF_AR;
          c.mem_cs  = 1'b0;
          c.mem_wr  = 1'b1;
        end
      end
      S_HALT:  c.halted = 1'b1;
      default: ;
    endcase
  end

  assign MuxASel     = c.mux_a;
  assign MuxBSel     = c.mux_b;
  assign MuxCSel     = c.mux_c;
  assign RF_OutASel  = c.rf_oa;
  assign RF_OutBSel  = c.rf_ob;
  assign RF_FunSel   = c.rf_fun;
  assign RF_RSel     = c.rf_rsel;
  assign RF_TSel     = c.rf_tsel;
  assign ALU_FunSel  = c.alu_fun;
  assign ARF_OutASel = c.arf_oa;
  assign ARF_OutBSel = c.arf_ob;
  assign ARF_FunSel  = c.arf_fun;
  assign ARF_RSel    = c.arf_rsel;
  assign IR_Funsel   = c.ir_fun;
  assign IR_Enable   = c.ir_en;
  assign IR_LH       = c.ir_lh;
  assign Mem_WR      = c.mem_wr;
  assign Mem_CS      = c.mem_cs;
  assign Halted      = c.halted;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: a behavioural ALU_System datapath driven by the DUT,
// with a scoreboard of expected (fetch address, cycle) pairs.
module tb_ctrl_unit;

  logic        Clock, Reset;
  logic [15:0] IR_Out;
  logic [3:0]  ZCNO;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  RF_OutASel, RF_OutBSel;
  logic [1:0]  RF_FunSel;
  logic [3:0]  RF_RSel, RF_TSel, ALU_FunSel;
  logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel;
  logic [3:0]  ARF_RSel;
  logic [1:0]  IR_Funsel;
  logic        IR_Enable, IR_LH, Mem_WR, Mem_CS, Halted;

  ctrl_unit dut (
    .Clock(Clock), .Reset(Reset), .IR_Out(IR_Out), .ZCNO(ZCNO),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RSel(RF_RSel), .RF_TSel(RF_TSel), .ALU_FunSel(ALU_FunSel),
    .ARF_OutASel(ARF_OutASel), .ARF_OutBSel(ARF_OutBSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RSel(ARF_RSel), .IR_Funsel(IR_Funsel), .IR_Enable(IR_Enable), .IR_LH(IR_LH),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- datapath model ----------------
  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        img_load = 1'b0;
  logic [15:0] ir = 16'h0;
  logic [7:0]  arf [4];
  logic [7:0]  rf [4];
  logic [7:0]  t [4];
  logic        z = 1'b0;
  logic [7:0]  rf_a, rf_b, alu_a, alu_out, mem_rd, mux_a_v, mux_b_v;

  assign IR_Out = ir;
  assign ZCNO   = {z, 3'b000};

  function automatic logic [7:0] apply(input logic [1:0] fs, input logic [7:0] cur, input logic [7:0] d);
    case (fs)
      2'b00:   return cur - 8'd1;
      2'b01:   return cur + 8'd1;
      2'b10:   return d;
      default: return 8'd0;
    endcase
  endfunction

  always_comb begin
    rf_a    = RF_OutASel[2] ? rf[RF_OutASel[1:0]] : t[RF_OutASel[1:0]];
    rf_b    = RF_OutBSel[2] ? rf[RF_OutBSel[1:0]] : t[RF_OutBSel[1:0]];
    alu_a   = MuxCSel ? arf[ARF_OutASel] : rf_a;
    case (ALU_FunSel)
      4'b0001: alu_out = rf_b;
      4'b0100: alu_out = alu_a + rf_b;
      4'b0101: alu_out = alu_a - rf_b;
      default: alu_out = 8'h00;
    endcase
    mem_rd  = mem[arf[ARF_OutBSel]];
    case (MuxASel)
      2'b00:   mux_a_v = alu_out;
      2'b01:   mux_a_v = mem_rd;
      2'b10:   mux_a_v = ir[7:0];
      default: mux_a_v = arf[ARF_OutASel];
    endcase
    case (MuxBSel)
      2'b00:   mux_b_v = alu_out;
      2'b01:   mux_b_v = mem_rd;
      2'b10:   mux_b_v = ir[7:0];
      default: mux_b_v = arf[ARF_OutASel];
    endcase
  end

  always @(posedge Clock) begin
    if (img_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (!Mem_CS && Mem_WR) begin
      mem[arf[ARF_OutBSel]] <= alu_out;
    end
    if (IR_Enable && IR_Funsel == 2'b10) begin
      if (IR_LH) ir[15:8] <= mem_rd;
      else       ir[7:0]  <= mem_rd;
    end
    for (int i = 0; i < 4; i++) begin
      if (RF_RSel[3-i]) rf[i] <= apply(RF_FunSel, rf[i], mux_a_v);
      if (RF_TSel[3-i]) t[i]  <= apply(RF_FunSel, t[i], mux_a_v);
    end
    for (int i = 0; i < 3; i++)
      if (ARF_RSel[3-i]) arf[i] <= apply(ARF_FunSel, arf[i], mux_b_v);
    if (ALU_FunSel == 4'b0100 || ALU_FunSel == 4'b0101) z <= (alu_out == 8'h00);
  end

  // ---------------- scoreboard / monitor ----------------
  typedef struct { logic [7:0] addr; int cyc; } fetch_t;
  fetch_t sb[$];
  int cyc = 0;
  int n_cmp = 0, n_err = 0, wr_cnt = 0;

  always @(posedge Clock) cyc <= Reset ? cyc + 1 : 0;

  always @(negedge Clock) begin
    if (Reset) begin
      if (!Mem_CS && Mem_WR) wr_cnt++;
      if (!Mem_CS && IR_Enable && !IR_LH && sb.size() > 0) begin
        fetch_t e;
        e = sb.pop_front();
        n_cmp++;
        if (arf[ARF_OutBSel] !== e.addr || cyc !== e.cyc) begin
          n_err++;
          $display("FAIL fetch: got addr %h at cyc %0d, want addr %h at cyc %0d",
                   arf[ARF_OutBSel], cyc, e.addr, e.cyc);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rx,
                                      input logic [1:0] ry, input logic [7:0] imm);
    return {op, rx, ry, imm};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic put(input logic [7:0] a, input logic [15:0] w);
    img[a]        = w[7:0];
    img[a + 8'd1] = w[15:8];
  endtask

  task automatic expect_fetch(input logic [7:0] a, input int c);
    fetch_t e;
    e.addr = a; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Reset for two cycles (optionally loading the image), release on a negedge.
  task automatic start(input logic load);
    Reset = 1'b0;
    img_load = load;
    sb.delete();
    wr_cnt = 0;
    cycles(2);
    img_load = 1'b0;
    Reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    #2;
    n_cmp++; if (Mem_CS !== 1'b1) begin n_err++; $display("FAIL rst_mem_cs: got %b want 1", Mem_CS); end
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", Halted); end
    n_cmp++; if (ARF_FunSel !== 2'b11 || ARF_RSel !== 4'b1110) begin n_err++;
      $display("FAIL rst_arf: got fun %b rsel %b want 11 1110", ARF_FunSel, ARF_RSel); end
    n_cmp++; if (RF_FunSel !== 2'b11 || RF_RSel !== 4'b1111) begin n_err++;
      $display("FAIL rst_rf: got fun %b rsel %b want 11 1111", RF_FunSel, RF_RSel); end
    n_cmp++; if (IR_Enable !== 1'b0 || Mem_WR !== 1'b0) begin n_err++;
      $display("FAIL rst_ir_mem: got ir_en %b wr %b want 0 0", IR_Enable, Mem_WR); end
  endtask

  task automatic test_alu();
    clear_img();
    put(8'h00, ins(4'h2, 2'd0, 2'd0, 8'h05));
    put(8'h02, ins(4'h2, 2'd1, 2'd0, 8'h03));
    put(8'h04, ins(4'h4, 2'd0, 2'd1, 8'h00));
    put(8'h06, ins(4'hF, 2'd0, 2'd0, 8'h00));
    start(1'b1);
    expect_fetch(8'h00, 1); expect_fetch(8'h02, 4); expect_fetch(8'h04, 7); expect_fetch(8'h06, 10);
    cycles(10);
    n_cmp++; if (rf[0] !== 8'h02) begin n_err++; $display("FAIL alu_r1: got %h want 02", rf[0]); end
    n_cmp++; if (rf[1] !== 8'h03) begin n_err++; $display("FAIL alu_r2: got %h want 03", rf[1]); end
    n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL alu_z: got %b want 0", z); end
    cycles(4);
    n_cmp++; if (wr_cnt !== 0) begin n_err++; $display("FAIL alu_nowrite: got %0d writes want 0", wr_cnt); end
    n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL alu_halt: got %b want 1", Halted); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL alu_sb: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_load_store();
    clear_img();
    img[8'h40] = 8'hA5;
    put(8'h00, ins(4'h0, 2'd2, 2'd0, 8'h40));
    put(8'h02, ins(4'h1, 2'd2, 2'd0, 8'h41));
    put(8'h04, ins(4'hF, 2'd0, 2'd0, 8'h00));
    start(1'b1);
    expect_fetch(8'h00, 1); expect_fetch(8'h02, 5); expect_fetch(8'h04, 9);
    cycles(13);
    n_cmp++; if (rf[2] !== 8'hA5) begin n_err++; $display("FAIL ld_r3: got %h want a5", rf[2]); end
    n_cmp++; if (mem[8'h41] !== 8'hA5) begin n_err++; $display("FAIL st_mem: got %h want a5", mem[8'h41]); end
    n_cmp++; if (arf[1] !== 8'h41) begin n_err++; $display("FAIL st_ar: got %h want 41", arf[1]); end
    n_cmp++; if (wr_cnt !== 1) begin n_err++; $display("FAIL st_wr_once: got %0d write cycles want 1", wr_cnt); end
    n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL ldst_halt: got %b want 1", Halted); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL ldst_sb: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_branch();
    clear_img();
    put(8'h00, ins(4'h2, 2'd0, 2'd0, 8'h03));
    put(8'h02, ins(4'h2, 2'd1, 2'd0, 8'h03));
    put(8'h04, ins(4'h4, 2'd0, 2'd1, 8'h00));
    put(8'h06, ins(4'h6, 2'd0, 2'd0, 8'h20));
    put(8'h20, ins(4'h4, 2'd0, 2'd1, 8'h00));
    put(8'h22, ins(4'h6, 2'd0, 2'd0, 8'h30));
    put(8'h24, ins(4'h5, 2'd0, 2'd0, 8'h40));
    put(8'h40, ins(4'hF, 2'd0, 2'd0, 8'h00));
    start(1'b1);
    expect_fetch(8'h00, 1);  expect_fetch(8'h02, 4);  expect_fetch(8'h04, 7);  expect_fetch(8'h06, 10);
    expect_fetch(8'h20, 13); expect_fetch(8'h22, 16); expect_fetch(8'h24, 19); expect_fetch(8'h40, 22);
    cycles(27);
    n_cmp++; if (rf[0] !== 8'hFD) begin n_err++; $display("FAIL br_r1: got %h want fd", rf[0]); end
    n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL br_halt: got %b want 1", Halted); end
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL br_sb: got %0d left want 0", sb.size()); end
  endtask

  // Continues from the halted state left by test_branch.
  task automatic test_halt();
    logic [7:0] pc0;
    pc0 = arf[0];
    cycles(12);
    n_cmp++; if (arf[0] !== pc0) begin n_err++; $display("FAIL halt_pc: got %h want %h", arf[0], pc0); end
    n_cmp++; if (Halted !== 1'b1) begin n_err++; $display("FAIL halt_hold: got %b want 1", Halted); end
    n_cmp++; if (Mem_CS !== 1'b1 || IR_Enable !== 1'b0 || RF_RSel !== 4'b0 || ARF_RSel !== 4'b0) begin n_err++;
      $display("FAIL halt_idle: got cs %b ir_en %b rf_rsel %b arf_rsel %b want 1 0 0000 0000",
               Mem_CS, IR_Enable, RF_RSel, ARF_RSel); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (Halted !== 1'b0 || ARF_RSel !== 4'b1110) begin n_err++;
      $display("FAIL halt_reset: got halted %b arf_rsel %b want 0 1110", Halted, ARF_RSel); end
  endtask

  task automatic test_reset_abort();
    clear_img();
    put(8'h00, ins(4'h2, 2'd2, 2'd0, 8'h77));
    put(8'h02, ins(4'h1, 2'd2, 2'd0, 8'h50));
    put(8'h04, ins(4'hF, 2'd0, 2'd0, 8'h00));
    start(1'b1);
    expect_fetch(8'h00, 1); expect_fetch(8'h02, 4);
    cycles(7);
    n_cmp++; if (Mem_WR !== 1'b1 || Mem_CS !== 1'b0) begin n_err++;
      $display("FAIL abort_st_ex1: got wr %b cs %b want 1 0", Mem_WR, Mem_CS); end
    Reset = 1'b0;
    #1;
    n_cmp++; if (Mem_CS !== 1'b1 || Mem_WR !== 1'b0) begin n_err++;
      $display("FAIL abort_cs: got cs %b wr %b want 1 0", Mem_CS, Mem_WR); end
    cycles(2);
    n_cmp++; if (mem[8'h50] !== 8'h00) begin n_err++; $display("FAIL abort_nostore: got %h want 00", mem[8'h50]); end
    Reset = 1'b1;
    expect_fetch(8'h00, 1);
    cycles(1);
    n_cmp++; if (arf[0] !== 8'h00) begin n_err++; $display("FAIL abort_pc: got %h want 00", arf[0]); end
    n_cmp++; if (rf[2] !== 8'h00 || rf[0] !== 8'h00) begin n_err++;
      $display("FAIL abort_rf_clr: got r3 %h r1 %h want 00 00", rf[2], rf[0]); end
    cycles(2);
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL abort_sb: got %0d left want 0", sb.size()); end
  endtask

  task automatic test_nop_wrap();
    clear_img();
    put(8'h00, ins(4'h5, 2'd0, 2'd0, 8'hFE));
    put(8'hFE, ins(4'h9, 2'd3, 2'd3, 8'h11));
    start(1'b1);
    expect_fetch(8'h00, 1); expect_fetch(8'hFE, 4); expect_fetch(8'h00, 7); expect_fetch(8'hFE, 10);
    cycles(11);
    n_cmp++; if (sb.size() !== 0) begin n_err++; $display("FAIL wrap_sb: got %0d left want 0", sb.size()); end
    n_cmp++; if (rf[3] !== 8'h00 || wr_cnt !== 0) begin n_err++;
      $display("FAIL nop_effect: got r4 %h writes %0d want 00 0", rf[3], wr_cnt); end
    n_cmp++; if (Halted !== 1'b0) begin n_err++; $display("FAIL nop_halt: got %b want 0", Halted); end
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_halt();
    test_reset_abort();
    test_nop_wrap();
    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
